// File: rtl/imem_boot_loader_if.sv
// Stream-in / instruction-memory-out bundle for the boot loader.
// The master drives the byte stream and start; the slave is the loader itself.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot sequencer: receives a length-prefixed, XOR-checksummed byte image, writes it
// word by word into instruction memory, and releases the core only after a good load.
module imem_boot_loader #(
    parameter int ADDR_W = 10
) (
    input logic               clk,
    input logic               reset,
    imem_boot_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, RUN, ERR} state_t;

    localparam logic [16:0]       CAPACITY = 17'(2 ** ADDR_W);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state;
    state_t            state_next;
    logic              ready;
    logic              accept;
    logic              word_end;
    logic              clear;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [15:0]       len_rx;
    logic [16:0]       word_cnt;
    logic [1:0]        lane;
    logic [23:0]       shreg;
    logic [7:0]        csum;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    assign ready    = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
    assign accept   = bus.rx_valid && ready;
    assign word_end = accept && (state == DATA) && (lane == 2'd3);
    assign len_rx   = {bus.rx_data, len_lo};
    assign clear    = (state == IDLE) || (bus.start && ((state == RUN) || (state == ERR)));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) state_next = LEN0;
            end
            LEN0: begin
                if (accept) state_next = LEN1;
            end
            LEN1: begin
                if (accept) begin
                    if ({1'b0, len_rx} > CAPACITY) state_next = ERR;
                    else if (len_rx == 16'd0)      state_next = CSUM;
                    else                           state_next = DATA;
                end
            end
            DATA: begin
                if (word_end && ((word_cnt + 17'd1) == {1'b0, len})) state_next = CSUM;
            end
            CSUM: begin
                if (accept) state_next = (bus.rx_data == csum) ? RUN : ERR;
            end
            RUN, ERR: begin
                if (bus.start) state_next = LEN0;
            end
            default: state_next = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they move with the state itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            state    <= state_next;
            busy     <= (state_next == LEN0) || (state_next == LEN1) ||
                        (state_next == DATA) || (state_next == CSUM);
            done     <= (state_next == RUN);
            err      <= (state_next == ERR);
            cpu_hold <= (state_next != RUN);
        end
    end

    // The address advances after each write strobe, so the strobe cycle shows the word's own address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_we    <= 1'b0;
            imem_wdata <= 32'd0;
            imem_addr  <= '0;
            len_lo     <= 8'd0;
            len        <= 16'd0;
            word_cnt   <= 17'd0;
            lane       <= 2'd0;
            shreg      <= 24'd0;
            csum       <= 8'd0;
        end else begin
            imem_we <= word_end;
            if (word_end) imem_wdata <= {bus.rx_data, shreg};
            if (clear) begin
                word_cnt  <= 17'd0;
                lane      <= 2'd0;
                csum      <= 8'd0;
                imem_addr <= '0;
            end else begin
                if (imem_we) imem_addr <= imem_addr + ADDR_ONE;
                if (accept && (state == LEN0)) len_lo <= bus.rx_data;
                if (accept && (state == LEN1)) len <= len_rx;
                if (accept && (state == DATA)) begin
                    lane <= lane + 2'd1;
                    csum <= csum ^ bus.rx_data;
                    if (lane != 2'd3) shreg <= {bus.rx_data, shreg[23:8]};
                    if (word_end) word_cnt <= word_cnt + 17'd1;
                end
            end
        end
    end

    assign bus.rx_ready   = ready;
    assign bus.imem_we    = imem_we;
    assign bus.imem_addr  = imem_addr;
    assign bus.imem_wdata = imem_wdata;
    assign bus.cpu_hold   = cpu_hold;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.err        = err;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: images are built from the format rules,
// expected writes are queued, and a monitor matches every write strobe against the queue.
module tb_imem_boot_loader;
    localparam int ADDR_W = 10;
    localparam int CAP    = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_data[$];
    int          exp_addr[$];

    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.imem_we === 1'b1) begin
            if (exp_data.size() == 0) begin
                check_output("unexpected_write", 32'(bus.imem_we), 32'd0);
            end else begin
                check_output("wr_addr", 32'(bus.imem_addr), 32'(exp_addr[0]));
                check_output("wr_data", bus.imem_wdata, exp_data[0]);
                void'(exp_addr.pop_front());
                void'(exp_data.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] payload_xor(input logic [31:0] words[$]);
        logic [7:0] x = 8'd0;
        foreach (words[i]) for (int k = 0; k < 4; k++) x = x ^ words[i][8*k +: 8];
        return x;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_output("start_busy", 32'(bus.busy), 32'd1);
        check_output("start_hold", 32'(bus.cpu_hold), 32'd1);
        check_output("start_ready", 32'(bus.rx_ready), 32'd1);
        check_output("start_done", 32'(bus.done), 32'd0);
        check_output("start_err", 32'(bus.err), 32'd0);
    endtask

    // Ends on the falling edge right after the last byte was taken, with rx_valid dropped.
    task automatic send_bytes(input logic [7:0] bytes[$], input bit gaps);
        foreach (bytes[i]) begin
            bit sent = 1'b0;
            int budget = 0;
            while (!sent) begin
                @(negedge clk);
                bus.rx_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.rx_data  = bus.rx_valid ? bytes[i] : 8'($urandom);
                if (bus.rx_valid && bus.rx_ready) sent = 1'b1;
                budget++;
                if (!sent && budget > 50) begin
                    check_output("ready_timeout", 32'(bus.rx_ready), 32'd1);
                    bus.rx_valid = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input int n, input logic [31:0] words[$],
                                  input logic [7:0] csum, input bit gaps);
        logic [7:0] bytes[$];
        bit         ok;
        int         n_written;
        pulse_start();
        bytes.push_back(n[7:0]);
        bytes.push_back(n[15:8]);
        n_written = 0;
        if (n <= CAP) begin
            foreach (words[i]) begin
                for (int k = 0; k < 4; k++) bytes.push_back(words[i][8*k +: 8]);
                exp_addr.push_back(i);
                exp_data.push_back(words[i]);
            end
            bytes.push_back(csum);
            n_written = n;
        end
        ok = (n <= CAP) && (csum == payload_xor(words));
        send_bytes(bytes, gaps);
        check_output("end_done", 32'(bus.done), 32'(ok));
        check_output("end_err", 32'(bus.err), 32'(!ok));
        check_output("end_hold", 32'(bus.cpu_hold), 32'(!ok));
        check_output("end_busy", 32'(bus.busy), 32'd0);
        check_output("end_ready", 32'(bus.rx_ready), 32'd0);
        @(negedge clk);
        check_output("pending_writes", 32'(exp_data.size()), 32'd0);
        check_output("end_addr", 32'(bus.imem_addr), 32'(n_written % CAP));
    endtask

    task automatic hold_valid_idle(input int cycles);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hAA;
        repeat (cycles) @(negedge clk);
        check_output("idle_ready", 32'(bus.rx_ready), 32'd0);
        bus.rx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] w[$];
        logic [7:0]  b[$];
        logic [7:0]  cs;
        int          n;

        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        $display("[TB] reset and idle checks");
        repeat (2) @(negedge clk);
        check_output("rst_hold", 32'(bus.cpu_hold), 32'd1);
        check_output("rst_ready", 32'(bus.rx_ready), 32'd0);
        check_output("rst_we", 32'(bus.imem_we), 32'd0);
        check_output("rst_addr", 32'(bus.imem_addr), 32'd0);
        check_output("rst_wdata", bus.imem_wdata, 32'd0);
        check_output("rst_busy", 32'(bus.busy), 32'd0);
        check_output("rst_done", 32'(bus.done), 32'd0);
        check_output("rst_err", 32'(bus.err), 32'd0);
        reset = 1'b1;
        hold_valid_idle(3);

        $display("[TB] two-word image, good then bad checksum");
        w = '{32'h00000513, 32'h00100593};
        apply_stimulus(2, w, payload_xor(w), 1'b0);
        hold_valid_idle(3);
        check_output("run_done_kept", 32'(bus.done), 32'd1);
        apply_stimulus(2, w, 8'h00, 1'b0);
        hold_valid_idle(3);
        check_output("err_kept", 32'(bus.err), 32'd1);
        w = '{$urandom, $urandom, $urandom};
        apply_stimulus(3, w, payload_xor(w), 1'b0);

        $display("[TB] oversize length and empty image");
        apply_stimulus(CAP + 1, w, 8'h00, 1'b0);
        hold_valid_idle(4);
        w = {};
        apply_stimulus(0, w, 8'h00, 1'b0);

        $display("[TB] random images with bubbles on rx_valid");
        w = '{$urandom, $urandom, $urandom, $urandom};
        apply_stimulus(4, w, payload_xor(w), 1'b1);
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 6);
            w = {};
            for (int i = 0; i < n; i++) w.push_back($urandom);
            cs = payload_xor(w);
            if ($urandom_range(0, 2) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
            apply_stimulus(n, w, cs, 1'b1);
        end

        $display("[TB] full-capacity image");
        w = {};
        for (int i = 0; i < CAP; i++) w.push_back($urandom);
        apply_stimulus(CAP, w, payload_xor(w), 1'b0);

        $display("[TB] reset in the middle of a load");
        pulse_start();
        w = '{$urandom, $urandom};
        b = '{8'h02, 8'h00};
        for (int k = 0; k < 4; k++) b.push_back(w[0][8*k +: 8]);
        b.push_back(w[1][7:0]);
        exp_addr.push_back(0);
        exp_data.push_back(w[0]);
        send_bytes(b, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_output("midrst_hold", 32'(bus.cpu_hold), 32'd1);
        check_output("midrst_busy", 32'(bus.busy), 32'd0);
        check_output("midrst_ready", 32'(bus.rx_ready), 32'd0);
        check_output("midrst_addr", 32'(bus.imem_addr), 32'd0);
        check_output("pending_writes", 32'(exp_data.size()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        w = '{$urandom, $urandom};
        apply_stimulus(2, w, payload_xor(w), 1'b1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
